// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control bundle between the sequencer (master) and the datapath/memories (slave).
// The retired counter is present only when CTRL_RETIRE_CNT_EN is defined.
interface multicycle_ctrl_if;
  logic run;
  logic [31:0] instruction;
  logic [1:0] alu_res_lo;
  logic inst_wr;
  logic pc_wr;
  logic [2:0] instruction_type;
  logic [3:0] reg_file_wr;
  logic [3:0] alu_op;
  logic alu_sel_1;
  logic alu_sel_2;
  logic [3:0] mem_wr;
  logic wb_sel;
  logic [2:0] branch;
  logic [2:0] state;
  logic illegal;
`ifdef CTRL_RETIRE_CNT_EN
  logic [31:0] retired;
  modport master (
    input run, instruction, alu_res_lo,
    output inst_wr, pc_wr, instruction_type, reg_file_wr, alu_op, alu_sel_1, alu_sel_2,
    mem_wr, wb_sel, branch, state, illegal, retired
  );
  modport slave (
    output run, instruction, alu_res_lo,
    input inst_wr, pc_wr, instruction_type, reg_file_wr, alu_op, alu_sel_1, alu_sel_2,
    mem_wr, wb_sel, branch, state, illegal, retired
  );
`else
  modport master (
    input run, instruction, alu_res_lo,
    output inst_wr, pc_wr, instruction_type, reg_file_wr, alu_op, alu_sel_1, alu_sel_2,
    mem_wr, wb_sel, branch, state, illegal
  );
  modport slave (
    output run, instruction, alu_res_lo,
    input inst_wr, pc_wr, instruction_type, reg_file_wr, alu_op, alu_sel_1, alu_sel_2,
    mem_wr, wb_sel, branch, state, illegal
  );
`endif
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multicycle control sequencer driving the data_path control inputs.
// Optional retired-instruction counter enabled by CTRL_RETIRE_CNT_EN.
module multicycle_ctrl #(
  parameter int MEM_LATENCY = 1,
  parameter bit TRAP_ON_MISALIGN = 1
) (
  input logic clk,
  input logic reset,
  multicycle_ctrl_if.master bus
);
  localparam int CW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
  localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OPI = 7'b0010011, OPC_LD = 7'b0000011,
                         OPC_ST = 7'b0100011, OPC_BR = 7'b1100011, OPC_AUIPC = 7'b0010111;
  typedef enum logic [2:0] {IDLE = 3'd0, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  state_t st, nxt;
  logic [31:0] ir;
  logic [CW-1:0] cnt;
  logic [6:0] opc;
  logic [2:0] f3;
  logic f7b, last, in_ins, in_alu, legal, mis, unused_ir;
  logic is_op, is_opi, is_ld, is_st, is_br, is_auipc;
  logic [2:0] itype, bcode;
  logic [3:0] aop, smask;
  assign opc = ir[6:0];
  assign f3 = ir[14:12];
  assign f7b = ir[30];
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};
  assign is_op = opc == OPC_OP;
  assign is_opi = opc == OPC_OPI;
  assign is_ld = opc == OPC_LD;
  assign is_st = opc == OPC_ST;
  assign is_br = opc == OPC_BR;
  assign is_auipc = opc == OPC_AUIPC;
  assign last = cnt == '0;
  assign in_ins = st inside {DECODE, EXEC, MEM, WB};
  assign in_alu = st inside {EXEC, MEM, WB};
  assign legal = is_op | is_opi | is_auipc | (is_ld & f3 != 3'b011 & f3[2:1] != 2'b11) |
                 (is_st & f3 < 3'b011) | (is_br & f3[2:1] != 2'b01);
  assign mis = (f3[1:0] == 2'b01 & bus.alu_res_lo[0]) | (f3[1:0] == 2'b10 & |bus.alu_res_lo);
  assign itype = is_op ? 3'd5 : is_st ? 3'd1 : is_br ? 3'd2 : is_auipc ? 3'd3 : 3'd0;
  assign aop = (is_ld | is_st | is_auipc) ? 4'd0 : is_br ? 4'd1 :
               f3 == 3'd0 ? {3'd0, is_op & f7b} : f3 == 3'd1 ? 4'd2 : f3 == 3'd2 ? 4'd3 :
               f3 == 3'd3 ? 4'd4 : f3 == 3'd4 ? 4'd5 : f3 == 3'd5 ? (f7b ? 4'd7 : 4'd6) :
               f3 == 3'd6 ? 4'd8 : 4'd9;
  assign bcode = f3 == 3'd0 ? 3'd1 : f3 == 3'd1 ? 3'd2 : f3 == 3'd4 ? 3'd3 :
                 f3 == 3'd5 ? 3'd5 : f3 == 3'd6 ? 3'd4 : 3'd6;
  // Lane masks use only alu_res_lo[1] for halves, so non-trapping misaligned stores land aligned
  assign smask = f3[1:0] == 2'b00 ? 4'b0001 << bus.alu_res_lo :
                 f3[1:0] == 2'b01 ? (bus.alu_res_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign bus.state = st;
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      ir <= '0;
      cnt <= '0;
    end else begin
      st <= nxt;
      if (st == FETCH && last) ir <= bus.instruction;
      cnt <= nxt != st ? CW'(MEM_LATENCY - 1) : cnt - CW'(cnt != '0);
    end
  end
  always_comb begin
    nxt = st;
    bus.inst_wr = 1'b0;
    bus.pc_wr = 1'b0;
    bus.reg_file_wr = 4'b0000;
    bus.mem_wr = 4'b0000;
    bus.wb_sel = 1'b0;
    bus.branch = 3'd0;
    bus.illegal = 1'b0;
    bus.instruction_type = in_ins ? itype : 3'd0;
    bus.alu_sel_1 = in_ins & is_auipc;
    bus.alu_sel_2 = in_ins & (is_opi | is_ld | is_st | is_auipc);
    bus.alu_op = in_alu ? aop : 4'd0;
    case (st)
      IDLE: nxt = bus.run ? FETCH : IDLE;
      FETCH: begin
        bus.inst_wr = last;
        nxt = last ? DECODE : FETCH;
      end
      DECODE: nxt = legal ? EXEC : TRAP;
      EXEC: begin
        bus.branch = is_br ? bcode : 3'd0;
        bus.pc_wr = is_br;
        nxt = is_br ? (bus.run ? FETCH : IDLE) :
              (is_ld | is_st) ? ((mis && TRAP_ON_MISALIGN) ? TRAP : MEM) : WB;
      end
      MEM: begin
        bus.mem_wr = is_st ? smask : 4'b0000;
        bus.pc_wr = is_st & last;
        nxt = !last ? MEM : is_st ? (bus.run ? FETCH : IDLE) : WB;
      end
      WB: begin
        bus.pc_wr = 1'b1;
        bus.reg_file_wr = is_ld ? {f3, 1'b1} : 4'b0101;
        bus.wb_sel = !is_ld;
        nxt = bus.run ? FETCH : IDLE;
      end
      TRAP: bus.illegal = 1'b1;
      default: nxt = IDLE;
    endcase
  end
`ifdef CTRL_RETIRE_CNT_EN
  always_ff @(posedge clk) bus.retired <= reset ? '0 : bus.retired + 32'(bus.pc_wr);
`endif
endmodule
